// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multi-cycle RV32I core: fetch/decode/exec/mem/wb sequencing and datapath enables.
// Optional performance counters (cycle_cnt, instret_cnt) are built when CTRL_PERF_CNT_EN is defined.
module multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 255,
    parameter int PERF_W      = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       instr,
    input  logic              imem_ready,
    input  logic              dmem_ready,
    input  logic              alu_zero,
    output logic              imem_req,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic              ir_we,
    output logic [2:0]        alu_op,
    output logic              reg_we,
    output logic [1:0]        wb_sel,
    output logic              pc_we,
    output logic              pc_sel,
    output logic [2:0]        state,
`ifdef CTRL_PERF_CNT_EN
    output logic [PERF_W-1:0] cycle_cnt,
    output logic [PERF_W-1:0] instret_cnt,
`endif
    output logic              trap
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'b000,
        S_DECODE = 3'b001,
        S_EXEC   = 3'b010,
        S_MEM    = 3'b011,
        S_WB     = 3'b100,
        S_TRAP   = 3'b111
    } state_t;

    localparam logic [2:0] C_R    = 3'b000;
    localparam logic [2:0] C_I    = 3'b001;
    localparam logic [2:0] C_S    = 3'b010;
    localparam logic [2:0] C_B    = 3'b011;
    localparam logic [2:0] C_U    = 3'b100;
    localparam logic [2:0] C_JAL  = 3'b101;
    localparam logic [2:0] C_LD   = 3'b110;
    localparam logic [2:0] C_JALR = 3'b111;

    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    state_t     cur, nxt;
    logic [2:0] cls, dec_cls;
    logic       ill, dec_ill;
    logic [7:0] wcnt;
    logic       wcnt_clr, wcnt_inc;
    logic       unused_bits;

    assign state       = cur;
    assign unused_bits = ^{instr[31:15], instr[11:7]};

    // Class and legality are worked out while the word is on the bus, so DECODE only has to branch.
    always_comb begin
        dec_cls = C_R;
        dec_ill = 1'b0;
        case (instr[6:0])
            7'b0110011: dec_cls = C_R;
            7'b0010011: dec_cls = C_I;
            7'b0100011: dec_cls = C_S;
            7'b1100011: begin dec_cls = C_B;  dec_ill = (instr[14:12] != 3'b000); end
            7'b0010111,
            7'b0110111: dec_cls = C_U;
            7'b1101111: dec_cls = C_JAL;
            7'b0000011: begin dec_cls = C_LD; dec_ill = (instr[14:12] != 3'b010); end
            7'b1100111: dec_cls = C_JALR;
            default:    dec_ill = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cur  <= S_FETCH;
            wcnt <= '0;
            cls  <= C_R;
            ill  <= 1'b0;
        end else begin
            cur <= nxt;
            if (wcnt_clr)      wcnt <= '0;
            else if (wcnt_inc) wcnt <= wcnt + 8'd1;
            if (cur == S_FETCH && imem_ready) begin
                cls <= dec_cls;
                ill <= dec_ill;
            end
        end
    end

    always_comb begin
        nxt      = cur;
        wcnt_clr = 1'b0;
        wcnt_inc = 1'b0;
        imem_req = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        ir_we    = 1'b0;
        alu_op   = C_R;
        reg_we   = 1'b0;
        wb_sel   = 2'b00;
        pc_we    = 1'b0;
        pc_sel   = 1'b0;
        trap     = 1'b0;
        case (cur)
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_we = 1'b1;
                    nxt   = S_DECODE;
                end else if (wcnt == WAIT_LAST) begin
                    nxt = S_TRAP;
                end else begin
                    wcnt_inc = 1'b1;
                end
            end
            S_DECODE: nxt = ill ? S_TRAP : S_EXEC;
            S_EXEC: begin
                alu_op = cls;
                case (cls)
                    C_S, C_LD: begin nxt = S_MEM; wcnt_clr = 1'b1; end
                    C_B: begin
                        pc_we    = 1'b1;
                        pc_sel   = alu_zero;
                        nxt      = S_FETCH;
                        wcnt_clr = 1'b1;
                    end
                    C_JAL, C_JALR: begin
                        reg_we   = 1'b1;
                        wb_sel   = 2'b10;
                        pc_we    = 1'b1;
                        pc_sel   = 1'b1;
                        nxt      = S_FETCH;
                        wcnt_clr = 1'b1;
                    end
                    default: nxt = S_WB;
                endcase
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (cls == C_S);
                if (dmem_ready) begin
                    if (cls == C_S) begin
                        pc_we    = 1'b1;
                        nxt      = S_FETCH;
                        wcnt_clr = 1'b1;
                    end else begin
                        nxt = S_WB;
                    end
                end else if (wcnt == WAIT_LAST) begin
                    nxt = S_TRAP;
                end else begin
                    wcnt_inc = 1'b1;
                end
            end
            S_WB: begin
                reg_we   = 1'b1;
                wb_sel   = (cls == C_LD) ? 2'b01 : 2'b00;
                pc_we    = 1'b1;
                nxt      = S_FETCH;
                wcnt_clr = 1'b1;
            end
            S_TRAP:  trap = 1'b1;
            default: nxt = S_TRAP;
        endcase
        // Nothing may fire while reset is held, even though the state register updates only at the edge.
        if (!rst_n) begin
            imem_req = 1'b0;
            dmem_req = 1'b0;
            dmem_we  = 1'b0;
            ir_we    = 1'b0;
            alu_op   = C_R;
            reg_we   = 1'b0;
            wb_sel   = 2'b00;
            pc_we    = 1'b0;
            pc_sel   = 1'b0;
            trap     = 1'b0;
        end
    end

`ifdef CTRL_PERF_CNT_EN
    // Every pc_we is the last one of its instruction, so it doubles as the retire strobe.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cycle_cnt   <= '0;
            instret_cnt <= '0;
        end else if (cur != S_TRAP) begin
            cycle_cnt <= cycle_cnt + 1'b1;
            if (pc_we) instret_cnt <= instret_cnt + 1'b1;
        end
    end
`endif

endmodule
